// File: rtl/bit_diff_pkg.sv
// Shared types and sizing helpers for the multi-bit bit-difference datapath.
package bit_diff_pkg;

  typedef enum logic [1:0] {
    MODE_DIFF  = 2'd0,
    MODE_ONES  = 2'd1,
    MODE_ZEROS = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int result_width(input int width);
    return $clog2(2 * width + 1);
  endfunction

  function automatic int acc_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int num_chunks(input int width, input int bpc);
    return (width + bpc - 1) / bpc;
  endfunction

  // Counter only has to reach N-1; keep at least one bit when N is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_diff_chunk_popcount.sv
// Combinational popcount of one chunk; bits whose mask is clear are not counted.
module bit_diff_chunk_popcount #(
  parameter int BITS = 4,
  parameter int CW   = $clog2(BITS + 1)
) (
  input  logic [BITS-1:0] bits,
  input  logic [BITS-1:0] valid_mask,
  output logic [CW-1:0]   count
);

  // Sum the set, valid bits of the chunk.
  always_comb begin
    count = '0;
    for (int j = 0; j < BITS; j++) begin
      if (bits[j] && valid_mask[j]) begin
        count = count + CW'(1);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/bit_diff_multi.sv
// Chunked bit-difference FSMD: counts ones BITS_PER_CYCLE bits per clock and
// reports ones-minus-zeros, ones or zeros under a go/done handshake.
module bit_diff_multi
  import bit_diff_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    go,
  input  logic [1:0]                              mode,
  input  logic [WIDTH-1:0]                        data,
  output logic                                    busy,
  output logic                                    done,
  output logic signed [result_width(WIDTH)-1:0]   result
);

  localparam int N     = num_chunks(WIDTH, BITS_PER_CYCLE);
  localparam int SR_W  = N * BITS_PER_CYCLE;
  localparam int ACC_W = acc_width(WIDTH);
  localparam int RW    = result_width(WIDTH);
  localparam int CNT_W = cnt_width(N);
  localparam int CW    = $clog2(BITS_PER_CYCLE + 1);

  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(N - 1);
  localparam logic signed [RW-1:0] WIDTH_S  = RW'(WIDTH);

  state_e               state_r;
  logic [SR_W-1:0]      sr_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [ACC_W-1:0]     acc_r;
  logic [1:0]           mode_r;
  logic                 busy_r;
  logic                 done_r;
  logic signed [RW-1:0] result_r;

  logic [BITS_PER_CYCLE-1:0] mask_s;
  logic [CW-1:0]             chunk_cnt_s;
  logic [ACC_W-1:0]          acc_next_s;
  logic signed [RW-1:0]      p_ext_s;
  logic signed [RW-1:0]      res_next_s;
  logic                      last_s;

  // Bit positions beyond WIDTH in the final chunk are excluded from the count.
  always_comb begin
    mask_s = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if ((int'(cnt_r) * BITS_PER_CYCLE + j) < WIDTH) begin
        mask_s[j] = 1'b1;
      end else begin
        mask_s[j] = 1'b0;
      end
    end
  end

  bit_diff_chunk_popcount #(
    .BITS (BITS_PER_CYCLE),
    .CW   (CW)
  ) u_chunk_popcount (
    .bits       (sr_r[BITS_PER_CYCLE-1:0]),
    .valid_mask (mask_s),
    .count      (chunk_cnt_s)
  );

  assign acc_next_s = acc_r + ACC_W'(chunk_cnt_s);
  assign last_s     = (cnt_r == LAST_CNT);

  // Post-process the final popcount according to the latched mode; reserved
  // mode falls through to DIFF. Intermediate 2*P may wrap, the final value fits.
  always_comb begin
    p_ext_s = RW'(acc_next_s);
    case (mode_r)
      MODE_ONES:  res_next_s = p_ext_s;
      MODE_ZEROS: res_next_s = WIDTH_S - p_ext_s;
      default:    res_next_s = (p_ext_s <<< 1) - WIDTH_S;
    endcase
  end

  // Control FSM with shift register, chunk counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sr_r     <= '0;
      cnt_r    <= '0;
      acc_r    <= '0;
      mode_r   <= 2'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (go) begin
            state_r <= BUSY;
            sr_r    <= SR_W'(data);
            mode_r  <= mode;
            cnt_r   <= '0;
            acc_r   <= '0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        BUSY: begin
          acc_r <= acc_next_s;
          sr_r  <= sr_r >> BITS_PER_CYCLE;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_s) begin
            state_r  <= DONE;
            result_r <= res_next_s;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_bit_diff_multi.sv
// Scoreboard bench for bit_diff_multi at three parameter points (16/4, 10/4, 1/1).
module tb_bit_diff_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic              go_a = 1'b0;
  logic [1:0]        mode_a = 2'd0;
  logic [15:0]       data_a = 16'd0;
  logic              busy_a, done_a;
  logic signed [5:0] result_a;

  logic              go_b = 1'b0;
  logic [1:0]        mode_b = 2'd0;
  logic [9:0]        data_b = 10'd0;
  logic              busy_b, done_b;
  logic signed [4:0] result_b;

  logic              go_c = 1'b0;
  logic [1:0]        mode_c = 2'd0;
  logic [0:0]        data_c = 1'b0;
  logic              busy_c, done_c;
  logic signed [1:0] result_c;

  int checks = 0;
  int errors = 0;
  int q_a[$];
  int q_b[$];
  int q_c[$];
  logic done_a_d = 1'b0, done_b_d = 1'b0, done_c_d = 1'b0;
  logic gd_c = 1'b0;

  always #5 clk = ~clk;

  bit_diff_multi #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .go(go_a), .mode(mode_a), .data(data_a),
    .busy(busy_a), .done(done_a), .result(result_a));

  bit_diff_multi #(.WIDTH(10), .BITS_PER_CYCLE(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go_b), .mode(mode_b), .data(data_b),
    .busy(busy_b), .done(done_b), .result(result_b));

  bit_diff_multi #(.WIDTH(1), .BITS_PER_CYCLE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .go(go_c), .mode(mode_c), .data(data_c),
    .busy(busy_c), .done(done_c), .result(result_c));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(input int w, input logic [1:0] m, input logic [15:0] d);
    int p;
    p = 0;
    for (int i = 0; i < w; i++) p += int'(d[i]);
    case (m)
      2'd1:    return p;
      2'd2:    return w - p;
      default: return 2 * p - w;
    endcase
  endfunction

  // Scoreboard monitors: a rising done pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (done_a && !done_a_d) begin
      if (q_a.size() == 0) check("a_spurious_done", 1, 0);
      else check("a_result", int'(result_a), q_a.pop_front());
    end
    done_a_d <= done_a;
  end

  always @(negedge clk) begin
    if (done_b && !done_b_d) begin
      if (q_b.size() == 0) check("b_spurious_done", 1, 0);
      else check("b_result", int'(result_b), q_b.pop_front());
    end
    done_b_d <= done_b;
  end

  always @(negedge clk) begin
    if (done_c && !done_c_d) begin
      if (q_c.size() == 0) check("c_spurious_done", 1, 0);
      else check("c_result", int'(result_c), q_c.pop_front());
    end
    done_c_d <= done_c;
  end

  // go accepted while done must drop done on the following cycle.
  always @(posedge clk) gd_c <= go_c && done_c;
  always @(negedge clk) begin
    if (gd_c) check("c_go_done_drops", int'(done_c), 0);
  end

  task automatic run_a(input logic [1:0] m, input logic [15:0] d, input int exp,
                       input bit interfere);
    int n;
    go_a = 1'b1; mode_a = m; data_a = d;
    q_a.push_back(exp);
    @(negedge clk);
    go_a = 1'b0; data_a = ~d; mode_a = ~m;
    check("a_busy_after_go", int'(busy_a), 1);
    check("a_done_low_after_go", int'(done_a), 0);
    if (interfere) begin
      go_a = 1'b1; data_a = 16'hFFFF; mode_a = 2'd1;
    end
    n = 0;
    do begin
      @(negedge clk);
      go_a = 1'b0;
      n++;
    end while (!done_a && n < 20);
    check("a_latency", n, 4);
    check("a_busy_low_at_done", int'(busy_a), 0);
  endtask

  task automatic run_b(input logic [1:0] m, input logic [9:0] d, input int exp);
    int n;
    go_b = 1'b1; mode_b = m; data_b = d;
    q_b.push_back(exp);
    @(negedge clk);
    go_b = 1'b0; data_b = ~d; mode_b = ~m;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_b && n < 20);
    check("b_latency", n, 3);
  endtask

  task automatic run_c(input logic [1:0] m, input logic d, input int exp);
    int n;
    go_c = 1'b1; mode_c = m; data_c = d;
    q_c.push_back(exp);
    @(negedge clk);
    go_c = 1'b0; data_c = ~d; mode_c = ~m;
    check("c_busy_after_go", int'(busy_c), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_c && n < 20);
    check("c_latency", n, 1);
  endtask

  initial begin
    logic [1:0] rm;
    logic       rd;

    #1 rst_n = 1'b0;
    #2;
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_result_a", int'(result_a), 0);
    check("rst_done_b", int'(done_b), 0);
    check("rst_result_c", int'(result_c), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_a(2'd0, 16'hFFFF, 16, 1'b0);
    run_a(2'd0, 16'h0000, -16, 1'b0);
    run_a(2'd0, 16'h00FF, 0, 1'b0);
    run_a(2'd0, 16'hFFFF, 16, 1'b0);
    run_a(2'd0, 16'h0001, -14, 1'b0);
    run_a(2'd0, 16'h0001, -14, 1'b1);
    run_a(2'd2, 16'h00FF, 8, 1'b0);
    run_a(2'd1, 16'hA5A5, 8, 1'b0);
    run_a(2'd3, 16'h000F, -8, 1'b0);
    run_a(2'd0, 16'h0001, -14, 1'b0);

    // Abort an operation two cycles into BUSY with an asynchronous reset.
    go_a = 1'b1; mode_a = 2'd0; data_a = 16'hFFFF;
    @(negedge clk);
    go_a = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy_a), 0);
    check("async_rst_done", int'(done_a), 0);
    check("async_rst_result", int'(result_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_a(2'd1, 16'h000F, 4, 1'b0);

    run_b(2'd1, 10'h3FF, 10);
    run_b(2'd2, 10'h001, 9);
    run_b(2'd0, 10'h2AA, 0);
    run_b(2'd0, 10'h3FF, 10);
    run_b(2'd2, 10'h000, 10);
    run_b(2'd0, 10'h200, -8);

    run_c(2'd0, 1'b1, 1);
    run_c(2'd0, 1'b0, -1);
    run_c(2'd2, 1'b0, 1);
    for (int i = 0; i < 10000; i++) begin
      rm = 2'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      run_c(rm, rd, model(1, rm, {15'd0, rd}));
    end

    @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    check("c_queue_drained", q_c.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
